// File: rtl/cache_fill_fsm.sv
// Miss-handling fill engine: on a cache miss, reads one aligned block from pipelined
// main memory, writes each returned word into the cache as it arrives, then writes
// the tag/valid entry. The pipeline is stalled (fsm_busy) for the whole fill.
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8,
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] memory_address,
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_data_out,
  output logic              data_write,
  output logic [OFF_W-1:0]  offset_write_fsm,
  output logic              tag_write,
  output logic              valid_bit,
  output logic              fsm_busy,
  output logic              fill_done
);

  // Counters need one extra bit so "all WORDS issued" is representable.
  localparam int CNT_W = OFF_W + 1;
  // Words are halfwords, so a block spans WORDS*2 bytes.
  localparam int BLOCK_BYTES = WORDS * 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  ret_cnt;
  logic [ADDR_W-1:0] base;

  // Byte offset of a word within the block (halfword granularity).
  function automatic logic [ADDR_W-1:0] word_byte(input logic [OFF_W-1:0] off);
    return ADDR_W'({off, 1'b0});
  endfunction

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Block base and issue/return counters; the block base is latched only when a miss is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
      base      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base      <= miss_address & ~ADDR_W'(BLOCK_BYTES - 1);
            issue_cnt <= '0;
            ret_cnt   <= '0;
          end
        end
        FILL: begin
          if (mem_req)           issue_cnt <= issue_cnt + 1'b1;
          if (memory_data_valid) ret_cnt   <= ret_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and outputs. Cache write path is combinational so a returned word is
  // written into the cache in the same cycle it arrives.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held (no latch).
    state_next       = state;
    mem_req          = 1'b0;
    memory_address   = '0;
    cache_address    = '0;
    cache_data_out   = '0;
    data_write       = 1'b0;
    offset_write_fsm = '0;
    tag_write        = 1'b0;
    valid_bit        = 1'b0;
    fsm_busy         = 1'b0;
    fill_done        = 1'b0;

    case (state)
      IDLE: begin
        // Stall in the same cycle the miss is seen; nothing is reported while in reset.
        fsm_busy = miss_detected & rst;
        if (miss_detected) state_next = FILL;
      end

      FILL: begin
        fsm_busy      = 1'b1;
        cache_address = base;
        if (issue_cnt < CNT_W'(WORDS)) begin
          mem_req        = 1'b1;
          // OR rather than add: base is block-aligned, so the address never leaves the block.
          memory_address = base | word_byte(issue_cnt[OFF_W-1:0]);
        end
        if (memory_data_valid) begin
          data_write       = 1'b1;
          offset_write_fsm = ret_cnt[OFF_W-1:0];
          cache_data_out   = memory_data_in;
          cache_address    = base | word_byte(ret_cnt[OFF_W-1:0]);
          if (ret_cnt == CNT_W'(WORDS - 1)) state_next = TAG;
        end
      end

      TAG: begin
        fsm_busy      = 1'b1;
        tag_write     = 1'b1;
        valid_bit     = 1'b1;
        fill_done     = 1'b1;
        cache_address = base;
        state_next    = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a behavioural pipelined memory answers the
// DUT's requests, and expected cache writes are queued as returns are driven and
// compared when the DUT performs the write.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data_in;
  logic        mem_req;
  logic [15:0] memory_address;
  logic [15:0] cache_address;
  logic [15:0] cache_data_out;
  logic        data_write;
  logic [2:0]  offset_write_fsm;
  logic        tag_write;
  logic        valid_bit;
  logic        fsm_busy;
  logic        fill_done;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data_in    (memory_data_in),
    .mem_req           (mem_req),
    .memory_address    (memory_address),
    .cache_address     (cache_address),
    .cache_data_out    (cache_data_out),
    .data_write        (data_write),
    .offset_write_fsm  (offset_write_fsm),
    .tag_write         (tag_write),
    .valid_bit         (valid_bit),
    .fsm_busy          (fsm_busy),
    .fill_done         (fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  off;
    logic [15:0] data;
    logic [15:0] addr;
  } wr_t;

  int total;
  int bad;

  // Memory model and scoreboards.
  logic [15:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [15:0] exp_iss_q[$];
  wr_t         exp_wr_q[$];
  logic        exp_dw;
  logic [15:0] cur_base;
  int          ret_idx;
  int          mode;      // 0: fixed latency, 1: gap pattern
  int          lat;
  logic [31:0] gap_pat;
  int          gap_i;
  int          cyc;

  // Per-test observations.
  int first_req, last_req, first_dw, last_dw, tag_cyc;
  int busy_first, busy_last, busy_cnt, n_dw, n_tag;
  int tot_tag, tot_done;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    first_req = -1; last_req = -1; first_dw = -1; last_dw = -1; tag_cyc = -1;
    busy_first = -1; busy_last = -1; busy_cnt = 0; n_dw = 0; n_tag = 0;
  endtask

  // Decide what memory returns this cycle and queue the cache write it should cause.
  task automatic drive_mem();
    logic        ready;
    logic [15:0] a;
    wr_t         w;
    memory_data_valid = 1'b0;
    memory_data_in    = 16'h0;
    exp_dw            = 1'b0;
    ready             = 1'b0;
    if (req_cyc_q.size() > 0) begin
      if (mode == 0) ready = (cyc >= req_cyc_q[0] + lat);
      else begin
        ready = (cyc > req_cyc_q[0]) && gap_pat[gap_i % 32];
        gap_i++;
      end
    end
    if (ready) begin
      void'(req_cyc_q.pop_front());
      a = req_addr_q.pop_front();
      memory_data_valid = 1'b1;
      memory_data_in    = mem_word(a);
      if (ret_idx < 8) begin
        exp_dw = 1'b1;
        w.off  = 3'(ret_idx);
        w.addr = cur_base | 16'(2 * ret_idx);
        w.data = mem_word(w.addr);
        exp_wr_q.push_back(w);
        ret_idx++;
      end
    end
  endtask

  // One clock: sample/compare at negedge, then advance and drive the next cycle's inputs.
  task automatic cycle();
    wr_t w;
    @(negedge clk);
    check("data_write", 32'(data_write), 32'(exp_dw));
    if (data_write) begin
      n_dw++;
      if (first_dw < 0) first_dw = cyc;
      last_dw = cyc;
      if (exp_wr_q.size() > 0) begin
        w = exp_wr_q.pop_front();
        check("wr_offset", 32'(offset_write_fsm), 32'(w.off));
        check("wr_data", 32'(cache_data_out), 32'(w.data));
        check("wr_addr", 32'(cache_address), 32'(w.addr));
      end
    end
    if (mem_req) begin
      if (first_req < 0) first_req = cyc;
      last_req = cyc;
      req_addr_q.push_back(memory_address);
      req_cyc_q.push_back(cyc);
      check("req_expected", 32'(exp_iss_q.size() > 0), 32'(1));
      if (exp_iss_q.size() > 0) check("mem_addr", 32'(memory_address), 32'(exp_iss_q.pop_front()));
    end
    if (tag_write) begin
      n_tag++;
      tot_tag++;
      tag_cyc = cyc;
      check("tag_addr", 32'(cache_address), 32'(cur_base));
      check("tag_valid", 32'(valid_bit), 32'(1));
      check("tag_done", 32'(fill_done), 32'(1));
    end
    if (fill_done) tot_done++;
    if (fsm_busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
      busy_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic start_miss(input logic [15:0] addr);
    check("iss_q_empty", 32'(exp_iss_q.size()), 32'(0));
    miss_detected = 1'b1;
    miss_address  = addr;
    cur_base      = addr & 16'hFFF0;
    ret_idx       = 0;
    for (int i = 0; i < 8; i++) exp_iss_q.push_back(cur_base | 16'(2 * i));
    cycle();
    miss_detected = 1'b0;
  endtask

  task automatic wait_tag(input int n);
    int k;
    k = 0;
    while (n_tag < n && k < 80) begin
      cycle();
      k++;
    end
    check("fill_timeout", 32'(n_tag), 32'(n));
  endtask

  initial begin
    int c0;
    int k;
    total = 0; bad = 0; cyc = 0; ret_idx = 8; mode = 0; lat = 4;
    gap_pat = 32'b1011_0010_1100_1110_0101_1001_0110_1101; gap_i = 0;
    exp_dw = 1'b0; cur_base = 16'h0; tot_tag = 0; tot_done = 0;
    rst = 1'b0; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data_valid = 1'b0; memory_data_in = 16'h0;
    clear_stats();

    // Reset state.
    #3;
    check("rst_busy", 32'(fsm_busy), 32'(0));
    check("rst_req", 32'(mem_req), 32'(0));
    check("rst_dw", 32'(data_write), 32'(0));
    check("rst_tag", 32'(tag_write), 32'(0));
    check("rst_caddr", 32'(cache_address), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: miss at 0x1236 with memory latency 4.
    clear_stats(); mode = 0; lat = 4;
    c0 = cyc;
    start_miss(16'h1236);
    wait_tag(1);
    cycle();
    check("t1_first_req", 32'(first_req - c0), 32'(1));
    check("t1_last_req", 32'(last_req - c0), 32'(8));
    check("t1_first_dw", 32'(first_dw - c0), 32'(5));
    check("t1_last_dw", 32'(last_dw - c0), 32'(12));
    check("t1_tag_cyc", 32'(tag_cyc - c0), 32'(13));
    check("t1_busy_first", 32'(busy_first - c0), 32'(0));
    check("t1_busy_last", 32'(busy_last - c0), 32'(13));
    check("t1_busy_cnt", 32'(busy_cnt), 32'(14));
    check("t1_n_dw", 32'(n_dw), 32'(8));

    // 2: gapped returns, block at top of address space (0xFFF0..0xFFFE).
    clear_stats(); mode = 1;
    start_miss(16'hFFF8);
    wait_tag(1);
    cycle();
    check("t2_n_dw", 32'(n_dw), 32'(8));
    check("t2_n_tag", 32'(n_tag), 32'(1));
    check("t2_tag_after_dw", 32'(tag_cyc > last_dw), 32'(1));
    check("t2_wr_q_empty", 32'(exp_wr_q.size()), 32'(0));

    // 3: second miss pulsed mid-fill is ignored.
    clear_stats(); mode = 0; lat = 3;
    start_miss(16'h1230);
    repeat (3) cycle();
    miss_detected = 1'b1;
    miss_address  = 16'h4000;
    cycle();
    miss_detected = 1'b0;
    wait_tag(1);
    cycle();
    check("t3_n_dw", 32'(n_dw), 32'(8));
    check("t3_iss_q_empty", 32'(exp_iss_q.size()), 32'(0));
    check("t3_busy_after", 32'(fsm_busy), 32'(0));

    // 4: reset after the third write aborts the fill; a new miss then fills cleanly.
    clear_stats(); mode = 0; lat = 2;
    start_miss(16'h3334);
    k = 0;
    while (n_dw < 3 && k < 40) begin
      cycle();
      k++;
    end
    check("t4_reach_3", 32'(n_dw), 32'(3));
    rst = 1'b0;
    #1;
    check("t4_abort_busy", 32'(fsm_busy), 32'(0));
    check("t4_abort_req", 32'(mem_req), 32'(0));
    check("t4_abort_dw", 32'(data_write), 32'(0));
    check("t4_abort_tag", 32'(tag_write), 32'(0));
    check("t4_abort_caddr", 32'(cache_address), 32'(0));
    check("t4_abort_maddr", 32'(memory_address), 32'(0));
    memory_data_valid = 1'b0; exp_dw = 1'b0; ret_idx = 8;
    req_addr_q.delete(); req_cyc_q.delete(); exp_iss_q.delete(); exp_wr_q.delete();
    cycle();
    rst = 1'b1;
    lat = 1;
    start_miss(16'h0080);
    wait_tag(1);
    cycle();
    check("t4_n_dw", 32'(n_dw), 32'(11));
    check("t4_n_tag", 32'(n_tag), 32'(1));

    // 5: back-to-back misses, second asserted in the IDLE cycle after TAG.
    clear_stats(); mode = 0; lat = 2;
    start_miss(16'h0010);
    wait_tag(1);
    start_miss(16'h0020);
    wait_tag(2);
    cycle();
    check("t5_n_dw", 32'(n_dw), 32'(16));
    check("t5_n_tag", 32'(n_tag), 32'(2));

    // 6: memory_data_valid in IDLE without a miss.
    clear_stats();
    repeat (3) begin
      memory_data_valid = 1'b1;
      memory_data_in    = 16'hBEEF;
      cycle();
    end
    check("t6_n_dw", 32'(n_dw), 32'(0));
    check("t6_busy_cnt", 32'(busy_cnt), 32'(0));

    check("tot_tag", 32'(tot_tag), 32'(6));
    check("tot_done", 32'(tot_done), 32'(6));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
